// File: rtl/matmul_pkg.sv
// matmul_pkg: shared defaults, FSM state encoding and element counts for the
// sequential 3x3 matrix-multiply controller.
package matmul_pkg;
    localparam int DEF_N      = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_LOAD    = 2'd1;
    localparam state_t S_COMPUTE = 2'd2;
    localparam state_t S_DRAIN   = 2'd3;

    localparam int NELEM = 9;
    localparam int NLOAD = 18;
    localparam int NMAC  = 27;
endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: registered multiply-accumulate with a first-term clear.
// MATMUL_SEQ_SAT_EN widens the accumulator by 2 bits and clamps the result.
module matmul_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  res_o
);
`ifdef MATMUL_SEQ_SAT_EN
    localparam int AW = ACC_W + 2;
`else
    localparam int AW = ACC_W;
`endif
    logic [2*DATA_W-1:0] prod;
    logic [AW-1:0]       acc_q, acc_d;

    assign prod  = a_i * b_i;
    assign acc_d = first_i ? AW'(prod) : acc_q + AW'(prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    acc_q <= '0;
        else if (en_i) acc_q <= acc_d;
    end

`ifdef MATMUL_SEQ_SAT_EN
    assign res_o = |acc_q[AW-1:ACC_W] ? '1 : acc_q[ACC_W-1:0];
`else
    assign res_o = acc_q;
`endif
endmodule

// File: rtl/matmul_seq.sv
// matmul_seq: 3x3 matrix multiply over one shared MAC with byte-stream load and
// valid/ready result drain. MATMUL_SEQ_SAT_EN selects saturating accumulation.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NELEM);
    localparam int QW = $clog2(NMAC);

    state_t            state_q, state_d;
    logic [QW-1:0]     idx_q, idx_d, lim;
    logic              done_q, done_d, wr_q, adv, at_end, k_first, k_last;
    logic [IW-1:0]     widx_q, mul_a, mul_b, c_idx;
    logic [DATA_W-1:0] a_q [NELEM];
    logic [DATA_W-1:0] b_q [NELEM];
    logic [ACC_W-1:0]  c_q [NELEM];
    logic [ACC_W-1:0]  mac_res;

    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
    assign in_ready  = state_q == S_LOAD;
    assign out_valid = state_q == S_DRAIN;
    assign out_data  = out_valid ? c_q[idx_q[IW-1:0]] : '0;
    assign out_last  = out_valid && idx_q == QW'(NELEM - 1);

    // One counter serves all phases; in COMPUTE it walks i,j,k with k fastest.
    always_comb begin
        mul_a   = IW'(int'(idx_q) / NN * N + int'(idx_q) % N);
        mul_b   = IW'(int'(idx_q) % N * N + int'(idx_q) / N % N);
        c_idx   = IW'(int'(idx_q) / N);
        k_first = int'(idx_q) % N == 0;
        k_last  = int'(idx_q) % N == N - 1;
    end

    always_comb begin
        lim     = state_q == S_LOAD ? QW'(NLOAD - 1) : state_q == S_COMPUTE ? QW'(NMAC - 1) : QW'(NELEM - 1);
        adv     = state_q == S_LOAD ? in_valid : state_q == S_COMPUTE ? 1'b1 : state_q == S_DRAIN && out_ready;
        at_end  = adv && idx_q == lim;
        idx_d   = (state_q == S_IDLE || at_end) ? '0 : idx_q + QW'(adv);
        state_d = state_q == S_IDLE ? (start ? S_LOAD : S_IDLE)
                : at_end ? (state_q == S_DRAIN ? S_IDLE : state_q + 2'd1) : state_q;
        done_d  = at_end && state_q == S_DRAIN;
    end

    // The MAC result lands one cycle after its k=2 product, so the write is delayed to match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            widx_q  <= '0;
            for (int e = 0; e < NELEM; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                c_q[e] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            wr_q    <= state_q == S_COMPUTE && k_last;
            widx_q  <= c_idx;
            if (in_ready && in_valid) begin
                if (idx_q < QW'(NELEM)) a_q[idx_q[IW-1:0]] <= in_data;
                else                    b_q[IW'(idx_q - QW'(NELEM))] <= in_data;
            end
            if (wr_q) c_q[widx_q] <= mac_res;
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q == S_COMPUTE),
        .first_i (k_first),
        .a_i     (a_q[mul_a]),
        .b_i     (b_q[mul_b]),
        .res_o   (mac_res)
    );
endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed self-checking bench for matmul_seq.
module tb_matmul_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_data = '0;
    logic        busy, done, in_ready, out_valid, out_last;
    logic [15:0] out_data;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ops [18];
    logic [15:0] res [9];
    int nres, lat, ndone, last_bad, hold_bad;

    always #5 clk = ~clk;

    matmul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // t counts clock edges since the cycle in which start is presented.
    task automatic run_job(input bit toggle, input bit pulse, input int stall_el, input int stall_len);
        int lcnt = 0;
        int scnt = 0;
        logic [15:0] held = '0;
        nres = 0; lat = -1; ndone = 0; last_bad = 0; hold_bad = 0;
        for (int i = 0; i < 9; i++) res[i] = '0;
        for (int t = 0; t < 400; t++) begin
            start     = (t == 0) || (pulse && (t == 3 || t == 25 || t == 50));
            in_valid  = lcnt < 18 && (!toggle || t % 2 == 1);
            in_data   = lcnt < 18 ? ops[lcnt] : 8'h00;
            out_ready = 1'b1;
            if (out_valid && nres == stall_el && scnt < stall_len) begin
                out_ready = 1'b0;
                if (scnt == 0) held = out_data;
                else if (out_data !== held) hold_bad++;
                scnt++;
            end else if (out_valid && nres == stall_el && stall_len > 0 && out_data !== held) begin
                hold_bad++;
            end
            if (out_last !== (out_valid && nres == 8)) last_bad++;
            if (in_valid && in_ready) lcnt++;
            if (out_valid && out_ready) begin
                if (nres < 9) res[nres] = out_data;
                nres++;
            end
            if (done) begin
                ndone++;
                if (lat < 0) lat = t;
            end
            if (lat >= 0 && t >= lat + 4) break;
            step();
        end
        start = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic load_seq_ops();
        for (int i = 0; i < 9; i++) begin
            ops[i]     = 8'(i + 1);
            ops[9 + i] = 8'(9 - i);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        step(); step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0d exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0d exp=0", out_last); end
        checks++; if (out_data !== 16'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        reset = 1'b1;
        step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%0d exp=0", busy); end
    endtask

    task automatic test_basic();
        logic [15:0] exp [9] = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90};
        load_seq_ops();
        run_job(1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 9; i++) begin
            checks++; if (res[i] !== exp[i]) begin failures++; $display("FAIL basic_c%0d got=%0d exp=%0d", i, res[i], exp[i]); end
        end
        checks++; if (nres !== 9) begin failures++; $display("FAIL basic_count got=%0d exp=9", nres); end
        checks++; if (lat !== 55) begin failures++; $display("FAIL basic_latency got=%0d exp=55", lat); end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", ndone); end
        checks++; if (last_bad !== 0) begin failures++; $display("FAIL basic_out_last got=%0d bad cycles exp=0", last_bad); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%0d exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        for (int s = 1; s <= 2; s++) begin
            for (int i = 0; i < 9; i++) begin
                ops[i]     = (i / 3 == i % 3) ? 8'(s) : 8'd0;
                ops[9 + i] = 8'(i + 1);
            end
            run_job(1'b0, 1'b0, -1, 0);
            for (int i = 0; i < 9; i++) begin
                checks++; if (res[i] !== 16'(s * (i + 1))) begin failures++; $display("FAIL ident%0d_c%0d got=%0d exp=%0d", s, i, res[i], s * (i + 1)); end
            end
            checks++; if (lat !== 55) begin failures++; $display("FAIL ident%0d_latency got=%0d exp=55", s, lat); end
            checks++; if (ndone !== 1) begin failures++; $display("FAIL ident%0d_done_pulses got=%0d exp=1", s, ndone); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp [9] = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90};
        load_seq_ops();
        run_job(1'b1, 1'b0, 4, 5);
        for (int i = 0; i < 9; i++) begin
            checks++; if (res[i] !== exp[i]) begin failures++; $display("FAIL bp_c%0d got=%0d exp=%0d", i, res[i], exp[i]); end
        end
        checks++; if (lat !== 77) begin failures++; $display("FAIL bp_latency got=%0d exp=77", lat); end
        checks++; if (hold_bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", hold_bad); end
        checks++; if (last_bad !== 0) begin failures++; $display("FAIL bp_out_last got=%0d bad cycles exp=0", last_bad); end
    endtask

    task automatic test_overflow();
`ifdef MATMUL_SEQ_SAT_EN
        logic [15:0] exp_v = 16'd65535;
`else
        logic [15:0] exp_v = 16'd64003;
`endif
        for (int i = 0; i < 18; i++) ops[i] = 8'hFF;
        run_job(1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 9; i++) begin
            checks++; if (res[i] !== exp_v) begin failures++; $display("FAIL ovf_c%0d got=%0d exp=%0d", i, res[i], exp_v); end
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] exp [9] = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90};
        load_seq_ops();
        run_job(1'b0, 1'b1, -1, 0);
        for (int i = 0; i < 9; i++) begin
            checks++; if (res[i] !== exp[i]) begin failures++; $display("FAIL start_ign_c%0d got=%0d exp=%0d", i, res[i], exp[i]); end
        end
        checks++; if (lat !== 55) begin failures++; $display("FAIL start_ign_latency got=%0d exp=55", lat); end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL start_ign_done_pulses got=%0d exp=1", ndone); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_ign_idle got=%0d exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 18; i++) ops[i] = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 18; b++) begin
            in_valid = 1'b1;
            in_data  = ops[b];
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%0d exp=1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0d exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%0d exp=0", done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%0d exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%0d exp=0", out_valid); end
        checks++; if (out_data !== 16'd0) begin failures++; $display("FAIL mid_rst_out_data got=%0d exp=0", out_data); end
        step(); step();
        reset = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            ops[i]     = (i / 3 == i % 3) ? 8'd1 : 8'd0;
            ops[9 + i] = 8'(i + 1);
        end
        run_job(1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 9; i++) begin
            checks++; if (res[i] !== 16'(i + 1)) begin failures++; $display("FAIL mid_new_c%0d got=%0d exp=%0d", i, res[i], i + 1); end
        end
        checks++; if (lat !== 55) begin failures++; $display("FAIL mid_new_latency got=%0d exp=55", lat); end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL mid_new_done_pulses got=%0d exp=1", ndone); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
